// File: rtl/multicycle_control.sv
// Multicycle RISC-V control unit: Moore FSM driving datapath selects, with
// same-cycle PC write enable, ALU control and immediate-type decode.
module multicycle_control (
  input  logic       i_clk,
  input  logic       i_arst,
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  output logic       o_pcWriteEn,
  output logic       o_adrSrc,
  output logic       o_irWrite,
  output logic       o_memWrite,
  output logic       o_regWrite,
  output logic [1:0] o_resultSrc,
  output logic [1:0] o_aluSrcA,
  output logic [1:0] o_aluSrcB,
  output logic [1:0] o_immSrc,
  output logic [2:0] o_aluControl,
  output logic [3:0] o_state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t     state_q, state_d;
  logic       pc_update, branch, ir_write, mem_write, reg_write, adr_src;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = FETCH;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state_q)
      FETCH: begin
        state_d    = DECODE;
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (i_op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTER;
          OP_I:         state_d = EXECUTEI;
          OP_JAL:       state_d = JAL;
          OP_BEQ:       state_d = BEQ;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        state_d   = (i_op == OP_LW) ? MEMREAD : MEMWRITE;
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD: begin
        state_d = MEMWB;
        adr_src = 1'b1;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      EXECUTER: begin
        state_d   = ALUWB;
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      EXECUTEI: begin
        state_d   = ALUWB;
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      ALUWB: reg_write = 1'b1;
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      JAL: begin
        state_d   = ALUWB;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset holds state at FETCH, so FETCH's write strobes are masked here.
  assign o_pcWriteEn = (pc_update | (branch & i_zero)) & ~i_arst;
  assign o_irWrite   = ir_write  & ~i_arst;
  assign o_memWrite  = mem_write & ~i_arst;
  assign o_regWrite  = reg_write & ~i_arst;
  assign o_adrSrc    = adr_src;
  assign o_resultSrc = result_src;
  assign o_aluSrcA   = alu_src_a;
  assign o_aluSrcB   = alu_src_b;
  assign o_state     = state_q;

  always_comb begin
    case (alu_op)
      2'b00: o_aluControl = 3'b000;
      2'b01: o_aluControl = 3'b001;
      2'b10: begin
        case (i_funct3)
          3'b000:  o_aluControl = (i_op[5] & i_funct7b5) ? 3'b001 : 3'b000;
          3'b010:  o_aluControl = 3'b101;
          3'b110:  o_aluControl = 3'b011;
          3'b111:  o_aluControl = 3'b010;
          default: o_aluControl = 3'b000;
        endcase
      end
      default: o_aluControl = 3'b000;
    endcase
  end

  always_comb begin
    case (i_op)
      OP_LW, OP_I: o_immSrc = 2'b00;
      OP_SW:       o_immSrc = 2'b01;
      OP_BEQ:      o_immSrc = 2'b10;
      OP_JAL:      o_immSrc = 2'b11;
      default:     o_immSrc = 2'b00;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// its state sequence and compares the full control word every cycle.
module tb_multicycle_control;

  logic       i_clk = 1'b0;
  logic       i_arst;
  logic [6:0] i_op;
  logic [2:0] i_funct3;
  logic       i_funct7b5;
  logic       i_zero;
  logic       o_pcWriteEn, o_adrSrc, o_irWrite, o_memWrite, o_regWrite;
  logic [1:0] o_resultSrc, o_aluSrcA, o_aluSrcB, o_immSrc;
  logic [2:0] o_aluControl;
  logic [3:0] o_state;

  int unsigned passed = 0;
  int unsigned failed = 0;
  int unsigned total  = 0;

  multicycle_control dut (
    .i_clk(i_clk), .i_arst(i_arst), .i_op(i_op), .i_funct3(i_funct3),
    .i_funct7b5(i_funct7b5), .i_zero(i_zero),
    .o_pcWriteEn(o_pcWriteEn), .o_adrSrc(o_adrSrc), .o_irWrite(o_irWrite),
    .o_memWrite(o_memWrite), .o_regWrite(o_regWrite), .o_resultSrc(o_resultSrc),
    .o_aluSrcA(o_aluSrcA), .o_aluSrcB(o_aluSrcB), .o_immSrc(o_immSrc),
    .o_aluControl(o_aluControl), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  // Word layout: {pcWE, adrSrc, irWrite, memWrite, regWrite, resultSrc, aluSrcA, aluSrcB, immSrc, aluControl, state}
  function automatic logic [19:0] pk(input logic [3:0] st, input logic pcwe, input logic adr,
                                     input logic ir, input logic mw, input logic rw,
                                     input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [1:0] imm,
                                     input logic [2:0] alu);
    return {pcwe, adr, ir, mw, rw, rs, sa, sb, imm, alu, st};
  endfunction

  function automatic logic [19:0] e_reset(input logic [1:0] imm);    return pk(4'd0, 0,0,0,0,0, 2'b10, 2'b00, 2'b10, imm, 3'b000); endfunction
  function automatic logic [19:0] e_fetch(input logic [1:0] imm);    return pk(4'd0, 1,0,1,0,0, 2'b10, 2'b00, 2'b10, imm, 3'b000); endfunction
  function automatic logic [19:0] e_decode(input logic [1:0] imm);   return pk(4'd1, 0,0,0,0,0, 2'b00, 2'b01, 2'b01, imm, 3'b000); endfunction
  function automatic logic [19:0] e_memadr(input logic [1:0] imm);   return pk(4'd2, 0,0,0,0,0, 2'b00, 2'b10, 2'b01, imm, 3'b000); endfunction
  function automatic logic [19:0] e_memread(input logic [1:0] imm);  return pk(4'd3, 0,1,0,0,0, 2'b00, 2'b00, 2'b00, imm, 3'b000); endfunction
  function automatic logic [19:0] e_memwb(input logic [1:0] imm);    return pk(4'd4, 0,0,0,0,1, 2'b01, 2'b00, 2'b00, imm, 3'b000); endfunction
  function automatic logic [19:0] e_memwrite(input logic [1:0] imm); return pk(4'd5, 0,1,0,1,0, 2'b00, 2'b00, 2'b00, imm, 3'b000); endfunction
  function automatic logic [19:0] e_execr(input logic [1:0] imm, input logic [2:0] alu); return pk(4'd6, 0,0,0,0,0, 2'b00, 2'b10, 2'b00, imm, alu); endfunction
  function automatic logic [19:0] e_execi(input logic [1:0] imm, input logic [2:0] alu); return pk(4'd8, 0,0,0,0,0, 2'b00, 2'b10, 2'b01, imm, alu); endfunction
  function automatic logic [19:0] e_aluwb(input logic [1:0] imm);    return pk(4'd7, 0,0,0,0,1, 2'b00, 2'b00, 2'b00, imm, 3'b000); endfunction
  function automatic logic [19:0] e_beq(input logic [1:0] imm, input logic pcwe); return pk(4'd10, pcwe,0,0,0,0, 2'b00, 2'b10, 2'b00, imm, 3'b001); endfunction
  function automatic logic [19:0] e_jal(input logic [1:0] imm);      return pk(4'd9, 1,0,0,0,0, 2'b00, 2'b01, 2'b10, imm, 3'b000); endfunction

  task automatic chk(input string tag, input logic [19:0] exp);
    logic [19:0] obs;
    obs = {o_pcWriteEn, o_adrSrc, o_irWrite, o_memWrite, o_regWrite, o_resultSrc,
           o_aluSrcA, o_aluSrcB, o_immSrc, o_aluControl, o_state};
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    @(negedge i_clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
    i_op = op; i_funct3 = f3; i_funct7b5 = f7; i_zero = z;
    #1;
  endtask

  initial begin
    i_arst = 1'b1; i_op = 7'b0000011; i_funct3 = 3'b010; i_funct7b5 = 1'b0; i_zero = 1'b0;
    #2;
    chk("reset_hold", e_reset(2'b00));
    @(negedge i_clk);
    i_arst = 1'b0;
    #1;

    // lw
    chk("lw_fetch", e_fetch(2'b00));
    tick(); chk("lw_decode", e_decode(2'b00));
    tick(); chk("lw_memadr", e_memadr(2'b00));
    tick(); chk("lw_memread", e_memread(2'b00));
    tick(); chk("lw_memwb", e_memwb(2'b00));
    tick(); chk("lw_end", e_fetch(2'b00));

    // sw
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    chk("sw_fetch", e_fetch(2'b01));
    tick(); chk("sw_decode", e_decode(2'b01));
    tick(); chk("sw_memadr", e_memadr(2'b01));
    tick(); chk("sw_memwrite", e_memwrite(2'b01));
    tick(); chk("sw_end", e_fetch(2'b01));

    // sub
    set_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
    chk("sub_fetch", e_fetch(2'b00));
    tick(); chk("sub_decode", e_decode(2'b00));
    tick(); chk("sub_execr", e_execr(2'b00, 3'b001));
    tick(); chk("sub_aluwb", e_aluwb(2'b00));
    tick(); chk("sub_end", e_fetch(2'b00));

    // I-type, funct3 000 with funct7b5=1 must still add
    set_instr(7'b0010011, 3'b000, 1'b1, 1'b0);
    tick(); chk("addi_decode", e_decode(2'b00));
    tick(); chk("addi_execi", e_execi(2'b00, 3'b000));
    tick(); chk("addi_aluwb", e_aluwb(2'b00));
    tick(); chk("addi_end", e_fetch(2'b00));

    // and / or / slt decode
    set_instr(7'b0110011, 3'b111, 1'b0, 1'b0);
    tick(); tick(); chk("and_execr", e_execr(2'b00, 3'b010));
    tick(); tick(); chk("and_end", e_fetch(2'b00));
    set_instr(7'b0010011, 3'b110, 1'b0, 1'b0);
    tick(); tick(); chk("ori_execi", e_execi(2'b00, 3'b011));
    tick(); tick();
    set_instr(7'b0110011, 3'b010, 1'b0, 1'b0);
    tick(); tick(); chk("slt_execr", e_execr(2'b00, 3'b101));
    tick(); tick();

    // beq taken
    set_instr(7'b1100011, 3'b000, 1'b0, 1'b1);
    chk("beqt_fetch", e_fetch(2'b10));
    tick(); chk("beqt_decode", e_decode(2'b10));
    tick(); chk("beqt_beq", e_beq(2'b10, 1'b1));
    tick(); chk("beqt_end", e_fetch(2'b10));

    // beq not taken
    set_instr(7'b1100011, 3'b000, 1'b0, 1'b0);
    tick(); chk("beqn_decode", e_decode(2'b10));
    tick(); chk("beqn_beq", e_beq(2'b10, 1'b0));
    tick(); chk("beqn_end", e_fetch(2'b10));

    // jal
    set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
    chk("jal_fetch", e_fetch(2'b11));
    tick(); chk("jal_decode", e_decode(2'b11));
    tick(); chk("jal_jal", e_jal(2'b11));
    tick(); chk("jal_aluwb", e_aluwb(2'b11));
    tick(); chk("jal_end", e_fetch(2'b11));

    // illegal opcode
    set_instr(7'b0000000, 3'b000, 1'b0, 1'b0);
    chk("ill_fetch", e_fetch(2'b00));
    tick(); chk("ill_decode", e_decode(2'b00));
    tick(); chk("ill_end", e_fetch(2'b00));

    // async reset mid-MEMREAD
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    tick(); tick(); tick(); chk("rst_pre_memread", e_memread(2'b00));
    i_arst = 1'b1;
    #1;
    chk("rst_async", e_reset(2'b00));
    tick(); chk("rst_held_edge", e_reset(2'b00));
    i_arst = 1'b0;
    #1;
    chk("rst_release_fetch", e_fetch(2'b00));
    tick(); chk("rst_first_edge", e_decode(2'b00));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none; all encodings SHALL be fixed as stated below.
REQ-002 i_clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 i_arst  input  1  reset, asynchronous, active-high.
REQ-004 i_op  input  7  opcode from instruction register, instr[6:0].
REQ-005 i_funct3  input  3  instr[14:12].
REQ-006 i_funct7b5  input  1  instr[30].
REQ-007 i_zero  input  1  ALU zero flag.
REQ-008 o_pcWriteEn  output  1  PC register load enable.
REQ-009 o_adrSrc  output  1  memory address select: 0 PC, 1 Result.
REQ-010 o_irWrite  output  1  instruction register load.
REQ-011 o_memWrite  output  1  data memory write.
REQ-012 o_regWrite  output  1  register file write.
REQ-013 o_resultSrc  output  2  00 ALUOut, 01 Data, 10 ALUResult.
REQ-014 o_aluSrcA  output  2  00 PC, 01 OldPC, 10 RD1.
REQ-015 o_aluSrcB  output  2  00 RD2, 01 ImmExt, 10 constant 4.
REQ-016 o_immSrc  output  2  I 00, S 01, B 10, J 11.
REQ-017 o_aluControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-018 o_state  output  4  current FSM state, for debug/verification.

Function
REQ-019 State encoding SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10.
REQ-020 Transitions: FETCH->DECODE; MEMREAD->MEMWB; MEMWB, MEMWRITE, ALUWB, BEQ->FETCH; EXECUTER, EXECUTEI, JAL->ALUWB.
REQ-021 DECODE SHALL go to: MEMADR for op 0000011/0100011; EXECUTER for 0110011; EXECUTEI for 0010011; JAL for 1101111; BEQ for 1100011; FETCH for any other opcode (illegal op = 2-cycle no-op).
REQ-022 MEMADR SHALL go to MEMREAD if op=0000011, else MEMWRITE.
REQ-023 Encodings 11-15 SHALL return to FETCH next cycle with all write enables 0.
REQ-024 Outputs SHALL be combinational from state (Moore), except o_pcWriteEn, o_aluControl, o_immSrc.
REQ-025 Per-state outputs; unlisted signals 0:
 - FETCH: adrSrc 0, irWrite 1, aluSrcA 00, aluSrcB 10, aluOp 00, resultSrc 10, pcUpdate 1.
 - DECODE: aluSrcA 01, aluSrcB 01, aluOp 00.
 - MEMADR: aluSrcA 10, aluSrcB 01, aluOp 00.
 - MEMREAD: resultSrc 00, adrSrc 1.
 - MEMWB: resultSrc 01, regWrite 1.
 - MEMWRITE: resultSrc 00, adrSrc 1, memWrite 1.
 - EXECUTER: aluSrcA 10, aluSrcB 00, aluOp 10.
 - EXECUTEI: aluSrcA 10, aluSrcB 01, aluOp 10.
 - ALUWB: resultSrc 00, regWrite 1.
 - BEQ: aluSrcA 10, aluSrcB 00, aluOp 01, resultSrc 00, branch 1.
 - JAL: aluSrcA 01, aluSrcB 10, aluOp 00, resultSrc 00, pcUpdate 1.
REQ-026 o_pcWriteEn SHALL equal pcUpdate OR (branch AND i_zero), same cycle.
REQ-027 ALU decode: aluOp 00 -> 000; 01 -> 001; 10 -> by funct3: 000 -> 001 if (i_op[5] AND i_funct7b5) else 000; 010 -> 101; 110 -> 011; 111 -> 010; others -> 000.
REQ-028 o_immSrc SHALL decode from i_op in every state: 0000011/0010011 -> 00, 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, others -> 00.
REQ-029 Cycles per instruction SHALL be: lw 5, sw 4, R-type 4, I-ALU 4, jal 4, beq 3.

Reset
REQ-030 i_arst assertion SHALL force state to FETCH immediately, without waiting for a clock edge, including mid-instruction.
REQ-031 While i_arst=1, o_pcWriteEn, o_irWrite, o_regWrite and o_memWrite SHALL be 0; other outputs take their FETCH values.
REQ-032 First rising edge after i_arst deasserts SHALL execute FETCH (PC+4 load, IR load).

Verification
REQ-033 lw (op 0000011): o_state 0,1,2,3,4,0; regWrite=1 only in state 4 with resultSrc 01; adrSrc=1 in state 3.
REQ-034 sw (op 0100011): states 0,1,2,5,0; memWrite=1 only in state 5; immSrc 01 throughout.
REQ-035 sub (op 0110011, funct3 000, funct7b5 1): aluControl 001 in EXECUTER; same inputs with op 0010011 -> aluControl 000.
REQ-036 beq: i_zero=1 in BEQ -> o_pcWriteEn=1; i_zero=0 -> o_pcWriteEn=0; both return to FETCH after 3 cycles.
REQ-037 jal: states 0,1,9,7,0; pcWriteEn=1 in states 0 and 9; regWrite=1 in state 7.
REQ-038 Illegal op 0000000 -> states 0,1,0, no writes; i_arst pulsed mid-MEMREAD -> o_state=0 before next edge, all write enables 0 during reset.
